// File: rtl/mmu_ptw_pkg.sv
// Shared widths, PTE field positions, walker state encoding and PTE decode for mmu_ptw.
package mmu_ptw_pkg;

    localparam int VPN_BITS    = 20;
    localparam int PFN_BITS    = 20;
    localparam int PTE_BITS    = 32;
    localparam int PADDR_BITS  = PFN_BITS + 12;
    localparam int PAGE_OFFSET = 12;
    localparam int VPN_HALF    = 10;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_PPN_LSB = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_REQ  = 3'd1,
        ST_L1_WAIT = 3'd2,
        ST_L0_REQ  = 3'd3,
        ST_L0_WAIT = 3'd4,
        ST_REFILL  = 3'd5,
        ST_FAULT   = 3'd6
    } ptw_state_t;

    typedef struct packed {
        logic                usable;
        logic                leaf;
        logic                misaligned;
        logic [PFN_BITS-1:0] ppn;
    } pte_dec_t;

    // misaligned only matters for an L1 leaf: a superpage needs PPN[9:0] == 0
    function automatic pte_dec_t pte_decode(input logic [PTE_BITS-1:0] pte);
        pte_dec_t d;
        d.ppn        = pte[PFN_BITS+PTE_PPN_LSB-1:PTE_PPN_LSB];
        d.usable     = pte[PTE_V] & ~(pte[PTE_W] & ~pte[PTE_R]);
        d.leaf       = pte[PTE_V] & (pte[PTE_R] | pte[PTE_X]);
        d.misaligned = (d.ppn[VPN_HALF-1:0] != '0);
        return d;
    endfunction

endpackage

// File: rtl/mmu_ptw_if.sv
// Single-outstanding PTE read port between the walker (master) and memory/cache (slave).
interface mmu_ptw_if;
    import mmu_ptw_pkg::*;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [PADDR_BITS-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [PTE_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

endinterface

// File: rtl/mmu_ptw.sv
// Two-level Sv32-style page-table walker: TLB miss in, PTE reads out, refill or fault strobe back.
//
// state   | meaning
// IDLE    | waiting for a TLB miss; miss_ready high
// L1_REQ  | root-level PTE read held until accepted
// L1_WAIT | waiting for root PTE; decide fault / superpage / descend
// L0_REQ  | leaf-level PTE read held until accepted
// L0_WAIT | waiting for leaf PTE; decide fault / refill
// REFILL  | one-cycle refill_en strobe
// FAULT   | one-cycle fault_valid strobe
module mmu_ptw
    import mmu_ptw_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PFN_BITS-1:0] ptbr,
    input  logic                miss_valid,
    input  logic [VPN_BITS-1:0] miss_vpn,
    output logic                miss_ready,
    mmu_ptw_if.master           mem,
    output logic                refill_en,
    output logic [VPN_BITS-1:0] refill_vpn,
    output logic [PFN_BITS-1:0] refill_pfn,
    output logic                fault_valid,
    output logic [VPN_BITS-1:0] fault_vpn,
    output logic                busy
);

    ptw_state_t          state_q, state_d;
    logic [VPN_BITS-1:0] vpn_q;
    logic [PFN_BITS-1:0] base_q;
    logic [PFN_BITS-1:0] pfn_q;
    pte_dec_t            dec;

    assign dec = pte_decode(mem.mem_resp_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (miss_valid)        state_d = ST_L1_REQ;
            ST_L1_REQ:  if (mem.mem_req_ready) state_d = ST_L1_WAIT;
            ST_L1_WAIT: if (mem.mem_resp_valid) begin
                if (!dec.usable)                    state_d = ST_FAULT;
                else if (dec.leaf && dec.misaligned) state_d = ST_FAULT;
                else if (dec.leaf)                  state_d = ST_REFILL;
                else                                state_d = ST_L0_REQ;
            end
            ST_L0_REQ:  if (mem.mem_req_ready) state_d = ST_L0_WAIT;
            ST_L0_WAIT: if (mem.mem_resp_valid) begin
                if (dec.usable && dec.leaf) state_d = ST_REFILL;
                else                        state_d = ST_FAULT;
            end
            ST_REFILL:  state_d = ST_IDLE;
            ST_FAULT:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        miss_ready        = 1'b0;
        busy              = 1'b1;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_addr  = '0;
        refill_en         = 1'b0;
        fault_valid       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                busy       = 1'b0;
            end
            ST_L1_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = {base_q, vpn_q[VPN_BITS-1:VPN_HALF], 2'b00};
            end
            ST_L0_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = {base_q, vpn_q[VPN_HALF-1:0], 2'b00};
            end
            ST_REFILL: refill_en   = 1'b1;
            ST_FAULT:  fault_valid = 1'b1;
            default: ;
        endcase
    end

    // base_q holds ptbr for the root read, then the L1 PPN for the leaf read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpn_q  <= '0;
            base_q <= '0;
            pfn_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (miss_valid) begin
                    vpn_q  <= miss_vpn;
                    base_q <= ptbr;
                end
                ST_L1_WAIT: if (mem.mem_resp_valid) begin
                    base_q <= dec.ppn;
                    pfn_q  <= {dec.ppn[PFN_BITS-1:VPN_HALF], vpn_q[VPN_HALF-1:0]};
                end
                ST_L0_WAIT: if (mem.mem_resp_valid) begin
                    pfn_q <= dec.ppn;
                end
                default: ;
            endcase
        end
    end

    assign refill_vpn = vpn_q;
    assign fault_vpn  = vpn_q;
    assign refill_pfn = pfn_q;

endmodule

// File: tb/tb_mmu_ptw.sv
// Scoreboard bench for mmu_ptw: a behavioural memory answers PTE reads, a monitor checks strobes and request addresses.
module tb_mmu_ptw;
    import mmu_ptw_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] ptbr = '0;
    logic        miss_valid = 1'b0;
    logic [19:0] miss_vpn = '0;
    logic        miss_ready;
    logic        refill_en;
    logic [19:0] refill_vpn;
    logic [19:0] refill_pfn;
    logic        fault_valid;
    logic [19:0] fault_vpn;
    logic        busy;

    mmu_ptw_if mem_bus();

    mmu_ptw dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ptbr        (ptbr),
        .miss_valid  (miss_valid),
        .miss_vpn    (miss_vpn),
        .miss_ready  (miss_ready),
        .mem         (mem_bus),
        .refill_en   (refill_en),
        .refill_vpn  (refill_vpn),
        .refill_pfn  (refill_pfn),
        .fault_valid (fault_valid),
        .fault_vpn   (fault_vpn),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fault;
        logic [19:0] vpn;
        logic [19:0] pfn;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] addr_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    bit          strobe_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (strobe_prev) check_val("ready_after_strobe", miss_ready, 1);
            if (refill_en || fault_valid) begin
                check_val("strobe_exclusive", refill_en & fault_valid, 0);
                check_val("busy_at_strobe", busy, 1);
                if (sb_q.size() == 0) begin
                    check_val("unexpected_strobe", {refill_en, fault_valid}, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("strobe_kind", fault_valid, e.fault);
                    check_val("strobe_cycle", cyc, e.cyc);
                    if (e.fault) check_val("fault_vpn", fault_vpn, e.vpn);
                    else begin
                        check_val("refill_vpn", refill_vpn, e.vpn);
                        check_val("refill_pfn", refill_pfn, e.pfn);
                    end
                end
            end
            if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
                hs_cnt++;
                if (addr_q.size() == 0) check_val("unexpected_req", mem_bus.mem_req_valid, 0);
                else                    check_val("req_addr", mem_bus.mem_req_addr, addr_q.pop_front());
            end
            strobe_prev = refill_en | fault_valid;
        end else begin
            strobe_prev = 1'b0;
        end
    end

    // Hold the request for 'stall' cycles (first one carries a spurious response), accept it, answer next cycle.
    task automatic mem_phase(input int stall, input logic [31:0] data);
        int n;
        for (int i = 0; i < stall; i++) begin
            mem_bus.mem_req_ready  = 1'b0;
            mem_bus.mem_resp_valid = (i == 0);
            mem_bus.mem_resp_data  = 32'h0;
            @(negedge clk);
            check_val("req_hold_valid", mem_bus.mem_req_valid, 1);
            check_val("req_hold_addr", mem_bus.mem_req_addr, addr_q[0]);
            @(posedge clk); #1;
        end
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_req_ready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_bus.mem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("req_seen", mem_bus.mem_req_valid, 1);
        @(posedge clk); #1;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = data;
        @(posedge clk); #1;
        mem_bus.mem_resp_valid = 1'b0;
    endtask

    task automatic walk(input logic [19:0] vpn, input logic [19:0] base,
                        input logic [31:0] l1, input logic [31:0] l0,
                        input int stall, input bit two_level, input bit fault,
                        input logic [19:0] pfn, input int lat);
        int n;
        int hs0;
        n = 0;
        while (!miss_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("miss_ready_idle", miss_ready, 1);
        hs0 = hs_cnt;
        ptbr       = base;
        miss_vpn   = vpn;
        miss_valid = 1'b1;
        addr_q.push_back({base, vpn[19:10], 2'b00});
        sb_q.push_back('{fault, vpn, pfn, cyc + lat});
        @(posedge clk); #1;
        miss_valid = 1'b0;
        mem_phase(stall, l1);
        if (two_level) begin
            addr_q.push_back({l1[29:10], vpn[9:0], 2'b00});
            mem_phase(0, l0);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("sb_drained", sb_q.size(), 0);
        check_val("handshakes", hs_cnt - hs0, two_level ? 2 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] v, b, p1, p0;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_miss_ready", miss_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_req_valid", mem_bus.mem_req_valid, 0);
        check_val("rst_req_addr", mem_bus.mem_req_addr, 0);
        check_val("rst_refill_en", refill_en, 0);
        check_val("rst_fault_valid", fault_valid, 0);
        check_val("rst_refill_pfn", refill_pfn, 0);
        check_val("rst_refill_vpn", refill_vpn, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // two-level walk, superpage, faults, invalid W-without-R, backpressure
        walk(20'h12345, 20'h00010, 32'h00008001, 32'h2AF37803, 0, 1, 0, 20'hABCDE, 5);
        walk(20'h12345, 20'h00010, 32'h10000003, 32'h0,        0, 0, 0, 20'h40345, 3);
        walk(20'h12345, 20'h00010, 32'h00000000, 32'h0,        0, 0, 1, 20'h0,     3);
        walk(20'h12345, 20'h00010, 32'h10000403, 32'h0,        0, 0, 1, 20'h0,     3);
        walk(20'h12345, 20'h00010, 32'h00008001, 32'h00008001, 0, 1, 1, 20'h0,     5);
        walk(20'h12345, 20'h00010, 32'h00008005, 32'h0,        0, 0, 1, 20'h0,     3);
        walk(20'h12345, 20'h00010, 32'h00008001, 32'h2AF37803, 3, 1, 0, 20'hABCDE, 8);

        for (int i = 0; i < 4; i++) begin
            v  = 20'($urandom);
            b  = 20'($urandom);
            p1 = 20'($urandom);
            p0 = 20'($urandom);
            walk(v, b, {2'b00, p1, 6'b0, 4'b0001}, {2'b00, p0, 6'b0, 4'b1001}, 0, 1, 0, p0, 5);
            walk(v, b, {2'b00, p1[19:10], 10'h0, 6'b0, 4'b1011}, 32'h0, 0, 0, 0, {p1[19:10], v[9:0]}, 3);
        end

        // reset while waiting for the L0 response, then a stale response
        check_val("pre_rst_ready", miss_ready, 1);
        ptbr = 20'h00010; miss_vpn = 20'h12345; miss_valid = 1'b1;
        addr_q.push_back(32'h00010120);
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        @(posedge clk); #1;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = 32'h00008001;
        addr_q.push_back(32'h00020D14);
        @(posedge clk); #1;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_req_ready  = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("midrst_miss_ready", miss_ready, 1);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_req_valid", mem_bus.mem_req_valid, 0);
        check_val("midrst_refill_en", refill_en, 0);
        check_val("midrst_fault_valid", fault_valid, 0);
        check_val("midrst_refill_pfn", refill_pfn, 0);
        check_val("midrst_fault_vpn", fault_vpn, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = 32'h2AF37803;
        @(posedge clk); #1;
        mem_bus.mem_resp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("stale_ignored_ready", miss_ready, 1);
        check_val("stale_ignored_busy", busy, 0);
        walk(20'h12345, 20'h00010, 32'h00008001, 32'h2AF37803, 0, 1, 0, 20'hABCDE, 5);

        repeat (2) @(posedge clk);
        check_val("addr_q_empty", addr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmu_ptw.md
# mmu_ptw

Hardware page-table walker (PTW) for the MMU. It accepts a TLB miss (VPN), performs a two-level Sv32-style walk over a single-outstanding memory read port, and drives the TLB refill interface (`refill_en`/`refill_vpn`/`refill_pfn`) or reports a page fault. It sits between the TLB miss path and the memory/cache request port, and replaces testbench-driven refills.

## Interface

Parameters (defaults in `mmu_params.vh`):
- `VPN_BITS`, 20: virtual page number width; split into VPN1 = upper half and VPN0 = lower half (10 bits each).
- `PFN_BITS`, 20: physical frame number width.
- `PTE_BITS`, 32: page-table entry width.
- `PADDR_BITS`, `PFN_BITS+12`: physical byte address width.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ptbr`, in, PFN_BITS: root page-table PFN; sampled at miss accept.
- `miss_valid`, in, 1: TLB miss request.
- `miss_vpn`, in, VPN_BITS: VPN that missed.
- `miss_ready`, out, 1: walker can accept a miss; high only in IDLE.
- `mem_req_valid`, out, 1: PTE read request.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_req_addr`, out, PADDR_BITS: PTE byte address.
- `mem_resp_valid`, in, 1: PTE data valid.
- `mem_resp_data`, in, PTE_BITS: PTE.
- `refill_en`, out, 1: one-cycle TLB write strobe.
- `refill_vpn`, out, VPN_BITS: VPN to install.
- `refill_pfn`, out, PFN_BITS: PFN to install.
- `fault_valid`, out, 1: one-cycle page-fault strobe.
- `fault_vpn`, out, VPN_BITS: faulting VPN.
- `busy`, out, 1: high in every state other than IDLE.

## Operation

- PTE format:
  - V = bit0, R = bit1, W = bit2, X = bit3.
  - leaf = V & (R | X).
  - PPN = pte[PFN_BITS+9:10].
  - invalid = !V, or (W & !R).
- PTE address = {ppn, vpn_i, 2'b00}, where ppn is `ptbr` at level 1 and the L1 PTE PPN at level 0.
- FSM states and transitions:
  - IDLE: on miss_valid & miss_ready, latch VPN and ptbr, go to L1_REQ.
  - L1_REQ: assert mem_req_valid; on mem_req_ready, go to L1_WAIT.
  - L1_WAIT: on mem_resp_valid:
    - invalid PTE → FAULT.
    - leaf with PPN[9:0] ≠ 0 (misaligned superpage) → FAULT.
    - aligned leaf → REFILL, with pfn = {PPN[PFN_BITS-1:10], VPN0}.
    - otherwise (non-leaf) → L0_REQ.
  - L0_REQ: same handshake as L1_REQ; then L0_WAIT.
  - L0_WAIT: on mem_resp_valid, invalid or non-leaf → FAULT; leaf → REFILL, with pfn = PPN.
  - REFILL: refill_en = 1 for one cycle, then IDLE.
  - FAULT: fault_valid = 1 for one cycle, then IDLE.
- Request signals:
  - mem_req_valid, once asserted, stays high with mem_req_addr stable until mem_req_ready.
  - Exactly one request is issued per level. No request is issued after a fault.
- Response signals:
  - mem_resp_valid is ignored in every state except L1_WAIT and L0_WAIT.
  - A late response to an abandoned request (after reset) is dropped.
- Outputs:
  - refill_vpn and fault_vpn always equal the latched VPN.
  - refill_pfn holds its last computed value; it is meaningful only while refill_en is high.
  - refill_en and fault_valid are never high in the same cycle.

## Timing

- Reset value of every output is 0, except miss_ready = 1 (FSM in IDLE). Latched VPN, ptbr and pfn reset to 0.
- Reset asserted mid-walk returns the FSM to IDLE immediately. No refill or fault strobe is emitted for the aborted walk.
- Minimum latency, with mem_req_ready held high and the response one cycle after the handshake:
  - cycle 0: miss accepted.
  - cycle 1: L1 request.
  - cycle 2: L1 response.
  - cycle 3: L0 request.
  - cycle 4: L0 response.
  - cycle 5: refill_en.
  - cycle 6: miss_ready.
- Superpage: refill_en in cycle 3. Fault at L1: fault_valid in cycle 3.
- A response is never expected in the same cycle as its request handshake.
- A new miss is accepted no earlier than the cycle after the REFILL or FAULT strobe. Back-to-back walks have no further bubble.

## Structure

- `mmu_params.vh` holds:
  - VPN_BITS, PFN_BITS, PTE_BITS, PADDR_BITS.
  - PTE bit positions (V/R/W/X, PPN LSB = 10).
  - Page offset (12) and VPN-half width.
  - FSM state encodings.
- Single module, no sub-modules.
- PTE decode (valid/leaf/misaligned) is a combinational function or block inside `mmu_ptw`.
- Top level wires `refill_*` to `tlb_simple`, and the TLB miss to `miss_*`.

## Test plan

Common setup: ptbr = 0x00010, miss_vpn = 0x12345.
- Two-level walk: L1 request addr 0x00010120; respond 0x00008001. L0 request addr 0x00020D14; respond 0x2AF37803. Required: refill_en pulse with vpn 0x12345, pfn 0xABCDE, at cycle 5.
- Superpage: L1 response 0x10000003. Required: no L0 request; refill_pfn 0x40345 in cycle 3.
- Faults, each giving one fault_valid pulse with fault_vpn 0x12345 and no refill_en:
  - L1 response 0x00000000: no L0 request.
  - L1 response 0x10000403 (misaligned superpage).
  - L0 response 0x00008001 (non-leaf at level 0).
- Backpressure: hold mem_req_ready low for 3 cycles. Required: mem_req_valid and mem_req_addr 0x00010120 stable throughout; exactly one handshake; a spurious mem_resp_valid during L1_REQ is ignored.
- Reset mid-walk: assert rst_n low in L0_WAIT, release, then drive a stale response. Required: all outputs reset, miss_ready = 1, no refill_en; a new miss walks correctly.
